axi_outstanding_limiter: RTL
============================

# axi_outstanding_limiter

Zero-latency AXI4 master-side gate that sits directly upstream of the AXI pipeline stage. It caps in-flight read bursts (AR accepted, final R beat not yet returned) and write bursts (AW accepted, B not yet returned) at configurable limits. It optionally blocks W data from running ahead of its AW. All channel payloads pass straight through; only the VALID/READY pairs on AR, AW and W are gated.

## Interface
- C_M_AXI_ID_WIDTH, 8, AXI ID width
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 512, data width
- C_M_AXI_WSTRB_WIDTH, C_M_AXI_DATA_WIDTH/8, strobe width
- MAX_OUTSTANDING_RD, 16, read burst limit, range 1..255
- MAX_OUTSTANDING_WR, 16, write burst limit, range 1..255
- CNT_WIDTH, 9, counter width, at least clog2(max limit + 1)
- ap_clk  in  1  clock; all state on rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- in_AW{VALID,ADDR,BURST,LEN,SIZE,ID} in / in_AWREADY out  AXI widths  upstream write-address channel
- in_W{VALID,DATA,STRB,LAST} in / in_WREADY out  AXI widths  upstream write-data channel
- in_B{VALID,RESP,ID} out / in_BREADY in  AXI widths  upstream write-response channel
- in_AR{VALID,ADDR,BURST,LEN,SIZE,ID} in / in_ARREADY out  AXI widths  upstream read-address channel
- in_R{VALID,DATA,LAST,ID,RESP} out / in_RREADY in  AXI widths  upstream read-data channel
- out_* (AW, W, B, AR, R)  mirror of in_*  AXI widths  downstream side, facing the pipeline
- rd_outstanding  out  CNT_WIDTH  current read count
- wr_outstanding  out  CNT_WIDTH  current write count
- proto_err  out  1  sticky flag: response received with its count at 0

## Operation
- Payloads are wired straight through in both directions. B and R VALID/READY are also wired straight through.
- Read gate: rd_ok = (rd_cnt < MAX_OUTSTANDING_RD).
  - out_ARVALID = in_ARVALID & rd_ok.
  - in_ARREADY = out_ARREADY & rd_ok.
  - VALID never depends on READY.
- rd_cnt: +1 on an out_AR handshake; −1 on an out_R handshake with RLAST=1.
  - Both in the same cycle: rd_cnt is unchanged.
- Write gate: works the same as the read gate, using wr_cnt and MAX_OUTSTANDING_WR.
- wr_cnt: +1 on an out_AW handshake; −1 on an out_B handshake. Simultaneous events net to zero.
- Underflow: a decrement event with its count at 0 leaves the count at 0 and sets proto_err.
  - proto_err clears only on reset.
- A count cannot exceed its MAX, because increments require the count to be below MAX.
- rd_outstanding and wr_outstanding are the registered counts.

## Timing
- Pass-through latency is 0 cycles. Gating is combinational on registered counts.
- Count changes are visible the cycle after the triggering handshake.
- A slot freed by RLAST or B at the limit enables AR or AW on the next cycle, not the same cycle.
- While ap_rst_n = 0:
  - all counts are 0 and proto_err = 0;
  - out_ARVALID, out_AWVALID, out_WVALID, in_ARREADY, in_AWREADY and in_WREADY are forced 0;
  - B and R still pass through.
- Reset asserted mid-burst clears all state immediately. Behaviour of responses that were in flight across the reset is the system's responsibility; a resulting underflow sets proto_err.

## Configuration
- Macro: AXI_OUTSTANDING_LIMITER_W_GATE_EN.
- When defined:
  - adds counter aw_pend (CNT_WIDTH bits): +1 on an out_AW handshake, −1 on an out_W handshake with WLAST=1, net 0 when both occur together;
  - out_WVALID = in_WVALID & (aw_pend != 0);
  - in_WREADY = out_WREADY & (aw_pend != 0);
  - W beats of a burst are therefore held until its AW is accepted, with a bubble of at least one cycle after the AW;
  - a WLAST handshake with aw_pend = 0 cannot occur.
- When undefined: W passes straight through, ungated except during reset, and aw_pend does not exist.

## Test plan
- MAX_OUTSTANDING_RD=4; 6 back-to-back AR with out_ARREADY=1, no R returned -> 4 accepted, in_ARREADY=0 and out_ARVALID=0 from the cycle after the 4th; rd_outstanding=4.
- At rd_cnt=4, one R beat with RLAST=1 -> rd_outstanding=3 the next cycle, and the 5th AR handshakes that same cycle.
- At rd_cnt=2, AR handshake and RLAST handshake in the same cycle -> rd_outstanding stays 2.
- MAX_OUTSTANDING_WR=2; 3 AW bursts of LEN=3 with W traffic, B held off -> third AW blocked; a B handshake -> third AW passes one cycle later.
- B handshake injected with wr_cnt=0 -> proto_err=1, wr_outstanding stays 0; ap_rst_n pulsed low asynchronously -> proto_err=0 with no clock edge.
- With W_GATE_EN: present W beats before any AW -> out_WVALID=0; AW accepted at cycle t -> first W beat passes at t+1; aw_pend returns to 0 after WLAST.

Source files
------------

// File: rtl/axi_outstanding_limiter.sv
// AXI4 outstanding-burst gate on AR/AW (optional W-behind-AW gate: AXI_OUTSTANDING_LIMITER_W_GATE_EN).
// Latency 0; at the limit AR/AW VALID and READY are both dropped, a freed slot reopens next cycle.
module axi_outstanding_limiter #(
    parameter int C_M_AXI_ID_WIDTH    = 8,
    parameter int C_M_AXI_ADDR_WIDTH  = 32,
    parameter int C_M_AXI_DATA_WIDTH  = 512,
    parameter int C_M_AXI_WSTRB_WIDTH = C_M_AXI_DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING_RD  = 16,
    parameter int MAX_OUTSTANDING_WR  = 16,
    parameter int CNT_WIDTH           = 9
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    // upstream AW
    input  logic                           in_AWVALID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_AWADDR,
    input  logic [1:0]                     in_AWBURST,
    input  logic [7:0]                     in_AWLEN,
    input  logic [2:0]                     in_AWSIZE,
    input  logic [C_M_AXI_ID_WIDTH-1:0]    in_AWID,
    output logic                           in_AWREADY,
    // upstream W
    input  logic                           in_WVALID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]  in_WDATA,
    input  logic [C_M_AXI_WSTRB_WIDTH-1:0] in_WSTRB,
    input  logic                           in_WLAST,
    output logic                           in_WREADY,
    // upstream B
    output logic                           in_BVALID,
    output logic [1:0]                     in_BRESP,
    output logic [C_M_AXI_ID_WIDTH-1:0]    in_BID,
    input  logic                           in_BREADY,
    // upstream AR
    input  logic                           in_ARVALID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]  in_ARADDR,
    input  logic [1:0]                     in_ARBURST,
    input  logic [7:0]                     in_ARLEN,
    input  logic [2:0]                     in_ARSIZE,
    input  logic [C_M_AXI_ID_WIDTH-1:0]    in_ARID,
    output logic                           in_ARREADY,
    // upstream R
    output logic                           in_RVALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]  in_RDATA,
    output logic                           in_RLAST,
    output logic [C_M_AXI_ID_WIDTH-1:0]    in_RID,
    output logic [1:0]                     in_RRESP,
    input  logic                           in_RREADY,
    // downstream AW
    output logic                           out_AWVALID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_AWADDR,
    output logic [1:0]                     out_AWBURST,
    output logic [7:0]                     out_AWLEN,
    output logic [2:0]                     out_AWSIZE,
    output logic [C_M_AXI_ID_WIDTH-1:0]    out_AWID,
    input  logic                           out_AWREADY,
    // downstream W
    output logic                           out_WVALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]  out_WDATA,
    output logic [C_M_AXI_WSTRB_WIDTH-1:0] out_WSTRB,
    output logic                           out_WLAST,
    input  logic                           out_WREADY,
    // downstream B
    input  logic                           out_BVALID,
    input  logic [1:0]                     out_BRESP,
    input  logic [C_M_AXI_ID_WIDTH-1:0]    out_BID,
    output logic                           out_BREADY,
    // downstream AR
    output logic                           out_ARVALID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]  out_ARADDR,
    output logic [1:0]                     out_ARBURST,
    output logic [7:0]                     out_ARLEN,
    output logic [2:0]                     out_ARSIZE,
    output logic [C_M_AXI_ID_WIDTH-1:0]    out_ARID,
    input  logic                           out_ARREADY,
    // downstream R
    input  logic                           out_RVALID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]  out_RDATA,
    input  logic                           out_RLAST,
    input  logic [C_M_AXI_ID_WIDTH-1:0]    out_RID,
    input  logic [1:0]                     out_RRESP,
    output logic                           out_RREADY,
    // status
    output logic [CNT_WIDTH-1:0]           rd_outstanding,
    output logic [CNT_WIDTH-1:0]           wr_outstanding,
    output logic                           proto_err
);

    logic [CNT_WIDTH-1:0] r_rd_cnt, r_wr_cnt;
    logic                 r_proto_err;
    logic                 w_rd_ok, w_wr_ok, w_w_ok;
    logic                 w_ar_hs, w_r_done, w_aw_hs, w_b_done, w_w_done;

    // Reset is folded into the gates so nothing is issued while held in reset.
    assign w_rd_ok = ap_rst_n && (r_rd_cnt < CNT_WIDTH'(MAX_OUTSTANDING_RD));
    assign w_wr_ok = ap_rst_n && (r_wr_cnt < CNT_WIDTH'(MAX_OUTSTANDING_WR));

    assign out_AWVALID = in_AWVALID & w_wr_ok;
    assign in_AWREADY  = out_AWREADY & w_wr_ok;
    assign out_WVALID  = in_WVALID & w_w_ok;
    assign in_WREADY   = out_WREADY & w_w_ok;
    assign out_ARVALID = in_ARVALID & w_rd_ok;
    assign in_ARREADY  = out_ARREADY & w_rd_ok;

    assign out_AWADDR  = in_AWADDR;
    assign out_AWBURST = in_AWBURST;
    assign out_AWLEN   = in_AWLEN;
    assign out_AWSIZE  = in_AWSIZE;
    assign out_AWID    = in_AWID;
    assign out_WDATA   = in_WDATA;
    assign out_WSTRB   = in_WSTRB;
    assign out_WLAST   = in_WLAST;
    assign out_ARADDR  = in_ARADDR;
    assign out_ARBURST = in_ARBURST;
    assign out_ARLEN   = in_ARLEN;
    assign out_ARSIZE  = in_ARSIZE;
    assign out_ARID    = in_ARID;

    assign in_BVALID  = out_BVALID;
    assign in_BRESP   = out_BRESP;
    assign in_BID     = out_BID;
    assign out_BREADY = in_BREADY;
    assign in_RVALID  = out_RVALID;
    assign in_RDATA   = out_RDATA;
    assign in_RLAST   = out_RLAST;
    assign in_RID     = out_RID;
    assign in_RRESP   = out_RRESP;
    assign out_RREADY = in_RREADY;

    assign w_ar_hs  = out_ARVALID & out_ARREADY;
    assign w_r_done = out_RVALID & out_RREADY & out_RLAST;
    assign w_aw_hs  = out_AWVALID & out_AWREADY;
    assign w_b_done = out_BVALID & out_BREADY;
    assign w_w_done = out_WVALID & out_WREADY & out_WLAST;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_ar_hs && !w_r_done)
                r_rd_cnt <= r_rd_cnt + 1'b1;
            else if (!w_ar_hs && w_r_done && r_rd_cnt != '0)
                r_rd_cnt <= r_rd_cnt - 1'b1;
            if (w_aw_hs && !w_b_done)
                r_wr_cnt <= r_wr_cnt + 1'b1;
            else if (!w_aw_hs && w_b_done && r_wr_cnt != '0)
                r_wr_cnt <= r_wr_cnt - 1'b1;
            // A response with nothing outstanding can only come from a broken upstream or a reset mid-flight.
            if ((w_r_done && r_rd_cnt == '0) || (w_b_done && r_wr_cnt == '0))
                r_proto_err <= 1'b1;
        end
    end

`ifdef AXI_OUTSTANDING_LIMITER_W_GATE_EN
    logic [CNT_WIDTH-1:0] r_aw_pend;

    assign w_w_ok = ap_rst_n && (r_aw_pend != '0);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            r_aw_pend <= '0;
        else if (w_aw_hs && !w_w_done)
            r_aw_pend <= r_aw_pend + 1'b1;
        else if (!w_aw_hs && w_w_done && r_aw_pend != '0)
            r_aw_pend <= r_aw_pend - 1'b1;
    end
`else
    assign w_w_ok = ap_rst_n;

    logic w_unused;
    assign w_unused = w_w_done;
`endif

    assign rd_outstanding = r_rd_cnt;
    assign wr_outstanding = r_wr_cnt;
    assign proto_err      = r_proto_err;

endmodule
